// File: rtl/ex_iter_mul_pkg.sv
// Shared definitions for the EX-stage iterative multiplier.
// Also holds the ALU decode value that routes MUL to this unit.
package ex_iter_mul_pkg;

  localparam int unsigned XlenDefault = 32;

  // ALUCtrl value that selects the MUL path; shared with the ALU decode.
  localparam logic [3:0] ALUCTRL_MUL = 4'b0101;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } mul_state_e;

endpackage

// File: rtl/ex_iter_mul_step.sv
// One iteration of the multiplier: acc + multiplicand * chunk, built as a
// shift-add of BITS_PER_CYCLE partial products so no wide multiplier is inferred.
module ex_iter_mul_step #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic [XLEN-1:0]           acc_i,
  input  logic [XLEN-1:0]           mcand_i,
  input  logic [BITS_PER_CYCLE-1:0] chunk_i,
  output logic [XLEN-1:0]           acc_next_o
);

  always_comb begin
    acc_next_o = acc_i;
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
      if (chunk_i[i]) begin
        acc_next_o = acc_next_o + (mcand_i << i);
      end
    end
  end

endmodule

// File: rtl/ex_iter_mul.sv
// Multi-cycle iterative multiplier beside the EX-stage ALU; returns the low
// XLEN bits of the product and stalls the pipeline through busy_o.
module ex_iter_mul
  import ex_iter_mul_pkg::*;
#(
  parameter int unsigned XLEN           = XlenDefault,
  parameter int unsigned BITS_PER_CYCLE = 1,
  parameter bit          EARLY_OUT      = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] data0_i,
  input  logic [XLEN-1:0] data1_i,
  input  logic [4:0]      rd_addr_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] data_o,
  output logic [4:0]      rd_addr_o
);

  localparam int unsigned NumIter = XLEN / BITS_PER_CYCLE;
  localparam int unsigned CntW    = $clog2(NumIter + 1);

  mul_state_e      state_q, state_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0] mplier_q, mplier_d;
  logic [4:0]      rd_q, rd_d;
  logic [CntW-1:0] count_q, count_d;
  logic [XLEN-1:0] data_q, data_d;
  logic [4:0]      rd_out_q, rd_out_d;
  logic [XLEN-1:0] acc_step;

  ex_iter_mul_step #(
    .XLEN           (XLEN),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_step (
    .acc_i      (acc_q),
    .mcand_i    (mcand_q),
    .chunk_i    (mplier_q[BITS_PER_CYCLE-1:0]),
    .acc_next_o (acc_step)
  );

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    rd_d     = rd_q;
    count_d  = count_q;
    data_d   = data_q;
    rd_out_d = rd_out_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          mcand_d  = data0_i;
          mplier_d = data1_i;
          rd_d     = rd_addr_i;
          acc_d    = '0;
          count_d  = CntW'(NumIter);
          if (EARLY_OUT && (data1_i == '0)) begin
            state_d  = StDone;
            data_d   = '0;
            rd_out_d = rd_addr_i;
          end else begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << BITS_PER_CYCLE;
        mplier_d = mplier_q >> BITS_PER_CYCLE;
        count_d  = count_q - CntW'(1);
        if ((count_q == CntW'(1)) || (EARLY_OUT && (mplier_d == '0))) begin
          state_d  = StDone;
          data_d   = acc_step;
          rd_out_d = rd_q;
        end
      end
      // start_i here still belongs to the completing instruction.
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (flush_i) begin
      state_d  = StIdle;
      data_d   = data_q;
      rd_out_d = rd_out_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      rd_q     <= '0;
      count_q  <= '0;
      data_q   <= '0;
      rd_out_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      rd_q     <= rd_d;
      count_q  <= count_d;
      data_q   <= data_d;
      rd_out_q <= rd_out_d;
    end
  end

  assign busy_o    = (state_q == StRun) | ((state_q == StIdle) & start_i & ~flush_i);
  assign done_o    = (state_q == StDone);
  assign data_o    = data_q;
  assign rd_addr_o = rd_out_q;

endmodule

// File: tb/tb_ex_iter_mul.sv
// Directed bench for ex_iter_mul: three configurations (1 bit/cycle, 1 bit/cycle
// with early out, 4 bits/cycle) driven from a vector table plus corner sequences.
module tb_ex_iter_mul;

  logic        clk;
  logic [2:0]  rst, start, flush, busy, done;
  logic [31:0] d0[3], d1[3], dout[3];
  logic [4:0]  rda[3], rdo[3];

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          cfg;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  ex_iter_mul #(.XLEN(32), .BITS_PER_CYCLE(1), .EARLY_OUT(1'b0)) u_b1 (
    .clk_i(clk), .rst_i(rst[0]), .start_i(start[0]), .flush_i(flush[0]),
    .data0_i(d0[0]), .data1_i(d1[0]), .rd_addr_i(rda[0]),
    .busy_o(busy[0]), .done_o(done[0]), .data_o(dout[0]), .rd_addr_o(rdo[0])
  );

  ex_iter_mul #(.XLEN(32), .BITS_PER_CYCLE(1), .EARLY_OUT(1'b1)) u_e1 (
    .clk_i(clk), .rst_i(rst[1]), .start_i(start[1]), .flush_i(flush[1]),
    .data0_i(d0[1]), .data1_i(d1[1]), .rd_addr_i(rda[1]),
    .busy_o(busy[1]), .done_o(done[1]), .data_o(dout[1]), .rd_addr_o(rdo[1])
  );

  ex_iter_mul #(.XLEN(32), .BITS_PER_CYCLE(4), .EARLY_OUT(1'b0)) u_b4 (
    .clk_i(clk), .rst_i(rst[2]), .start_i(start[2]), .flush_i(flush[2]),
    .data0_i(d0[2]), .data1_i(d1[2]), .rd_addr_i(rda[2]),
    .busy_o(busy[2]), .done_o(done[2]), .data_o(dout[2]), .rd_addr_o(rdo[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start an op, hold start_i through DONE (as a stalled pipeline would), then
  // check latency, result, and that exactly one done pulse appears.
  task automatic run_op(input int c, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp, input int lat);
    int n;
    bit got;
    int extra;
    d0[c] = a; d1[c] = b; rda[c] = rd; start[c] = 1'b1;
    #1;
    check("busy_at_start", 32'(busy[c]), 32'd1);
    n = 0; got = 1'b0;
    while (!got && n < 100) begin
      tick();
      n++;
      if (done[c]) got = 1'b1;
      else if (!busy[c]) check("busy_while_running", 32'(busy[c]), 32'd1);
    end
    check("done_latency", 32'(n), 32'(lat));
    if (got) begin
      check("data_o", dout[c], exp);
      check("rd_addr_o", 32'(rdo[c]), 32'(rd));
      check("busy_in_done", 32'(busy[c]), 32'd0);
    end
    tick();
    start[c] = 1'b0;
    #1;
    check("done_after_done", 32'(done[c]), 32'd0);
    check("busy_after_done", 32'(busy[c]), 32'd0);
    extra = 0;
    repeat (3) begin
      tick();
      if (done[c] || busy[c]) extra++;
    end
    check("single_done_idle", 32'(extra), 32'd0);
  endtask

  initial begin
    int quiet;
    vecs[0] = '{0, 32'd7,        32'd6,        5'd5,  32'd42,       33};
    vecs[1] = '{0, 32'hFFFFFFFD, 32'd5,        5'd1,  32'hFFFFFFF1, 33};
    vecs[2] = '{0, 32'h80000000, 32'd2,        5'd2,  32'h00000000, 33};
    vecs[3] = '{1, 32'd123,      32'd0,        5'd3,  32'h00000000, 1};
    vecs[4] = '{1, 32'h1234,     32'd3,        5'd4,  32'h0000369C, 3};
    vecs[5] = '{1, 32'd5,        32'd9,        5'd6,  32'd45,       5};
    vecs[6] = '{1, 32'h10,       32'h80000000, 5'd7,  32'h00000000, 33};
    vecs[7] = '{2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd31, 32'h00000001, 9};
    vecs[8] = '{2, 32'h12345678, 32'h10,       5'd8,  32'h23456780, 9};
    vecs[9] = '{1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd10, 32'h00000001, 33};

    rst = 3'b111; start = '0; flush = '0;
    for (int c = 0; c < 3; c++) begin
      d0[c] = '0; d1[c] = '0; rda[c] = '0;
    end
    repeat (3) tick();
    for (int c = 0; c < 3; c++) begin
      check("reset_busy", 32'(busy[c]), 32'd0);
      check("reset_done", 32'(done[c]), 32'd0);
      check("reset_data", dout[c], 32'd0);
      check("reset_rd", 32'(rdo[c]), 32'd0);
    end
    rst = 3'b000;
    tick();

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].cfg, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp, vecs[i].lat);
    end

    // Flush mid-run on the early-out unit; last result there is 1 / rd 10.
    d0[1] = 32'd3; d1[1] = 32'hFFFFFFFF; rda[1] = 5'd20; start[1] = 1'b1;
    repeat (10) tick();
    flush[1] = 1'b1;
    #1;
    check("flush_busy_run", 32'(busy[1]), 32'd1);
    tick();
    flush[1] = 1'b0; start[1] = 1'b0;
    #1;
    check("flush_busy", 32'(busy[1]), 32'd0);
    check("flush_done", 32'(done[1]), 32'd0);
    check("flush_data_kept", dout[1], 32'd1);
    check("flush_rd_kept", 32'(rdo[1]), 32'd10);
    quiet = 0;
    repeat (40) begin
      tick();
      if (done[1] || busy[1]) quiet++;
    end
    check("flush_no_done", 32'(quiet), 32'd0);

    // Start coincident with flush is dropped.
    d1[1] = 32'd5; start[1] = 1'b1; flush[1] = 1'b1;
    #1;
    check("start_flush_busy", 32'(busy[1]), 32'd0);
    tick();
    start[1] = 1'b0; flush[1] = 1'b0;
    quiet = 0;
    repeat (5) begin
      tick();
      if (done[1] || busy[1]) quiet++;
    end
    check("start_flush_ignored", 32'(quiet), 32'd0);
    run_op(1, 32'd2, 32'd3, 5'd12, 32'd6, 3);

    // Reset mid-run on the 4-bit unit; last result there is 0x23456780 / rd 8.
    d0[2] = 32'd3; d1[2] = 32'd7; rda[2] = 5'd11; start[2] = 1'b1;
    repeat (5) tick();
    rst[2] = 1'b1; start[2] = 1'b0;
    tick();
    rst[2] = 1'b0;
    #1;
    check("rst_busy", 32'(busy[2]), 32'd0);
    check("rst_done", 32'(done[2]), 32'd0);
    check("rst_data", dout[2], 32'd0);
    check("rst_rd", 32'(rdo[2]), 32'd0);
    quiet = 0;
    repeat (12) begin
      tick();
      if (done[2] || busy[2]) quiet++;
    end
    check("rst_no_done", 32'(quiet), 32'd0);
    run_op(2, 32'd3, 32'd7, 5'd11, 32'd21, 9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
